// File: rtl/jtag_pkg.sv
// Shared types and helpers for the JTAG data-register TX scheduler.
// Exports: sched_state_t, DR_WORD_W, slice_lsb().
package jtag_pkg;

    localparam int unsigned DR_WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOADED   = 2'd1,
        ST_SHIFT    = 2'd2,
        ST_COMPLETE = 2'd3
    } sched_state_t;

    // LSB position of word idx inside a flattened bus of width-bit words.
    function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted req scanning upward from rr_ptr, with wrap.
// Ports: req (request vector), rr_ptr (scan start), winner_idx_c (winning index),
//        any_req_c (at least one request asserted).
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDXW-1:0]    rr_ptr,
    output logic [IDXW-1:0]    winner_idx_c,
    output logic               any_req_c
);

    // Candidate index at scan distance k from the pointer.
    logic [IDXW-1:0] cand [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
        assign cand[k] = IDXW'((32'(rr_ptr) + 32'(k)) % NUM_REQ);
    end

    // Scan from farthest to nearest so the nearest asserted candidate wins.
    always_comb begin
        winner_idx_c = '0;
        any_req_c    = 1'b0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                winner_idx_c = cand[k];
                any_req_c    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtag_dr_tx_scheduler.sv
// Arbitrates DR scan requesters at Capture-DR, loads the shared TDO serializer,
// gates its enable through Shift-DR and acknowledges completed scans at Update-DR.
// Ports: clk_tck/reset (sync, active-high); capture_dr/shift_dr/update_dr TAP phase flags;
//        req/req_data requester levels and flattened words; tx_data/tx_enable/tx_reset
//        serializer controls, tx_done serializer completion; ack one-hot completion pulse;
//        abort abandoned-scan pulse; busy non-idle; grant_idx/grant_valid latched grant.
module jtag_dr_tx_scheduler
    import jtag_pkg::*;
#(
    parameter  int unsigned         NUM_REQ      = 4,
    parameter  int unsigned         WORD_W       = DR_WORD_W,
    parameter  logic [WORD_W-1:0]   DEFAULT_WORD = '0,
    localparam int unsigned         IDXW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk_tck,
    input  logic                        reset,
    input  logic                        capture_dr,
    input  logic                        shift_dr,
    input  logic                        update_dr,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*WORD_W-1:0]   req_data,
    output logic [WORD_W-1:0]           tx_data,
    output logic                        tx_enable,
    output logic                        tx_reset,
    input  logic                        tx_done,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        abort,
    output logic                        busy,
    output logic [IDXW-1:0]             grant_idx,
    output logic                        grant_valid
);

    sched_state_t        state, state_nxt;
    logic [IDXW-1:0]     rr_ptr, rr_ptr_nxt;
    logic [WORD_W-1:0]   tx_data_nxt;
    logic                tx_enable_nxt, tx_reset_nxt, abort_nxt, busy_nxt, grant_valid_nxt;
    logic [NUM_REQ-1:0]  ack_nxt;
    logic [IDXW-1:0]     grant_idx_nxt;
    logic                abandon_c;
    logic [IDXW-1:0]     win_idx_c;
    logic                any_req_c;

    // Unflattened view of the requester words.
    logic [WORD_W-1:0]   req_words [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
        assign req_words[i] = req_data[slice_lsb(i, WORD_W) +: WORD_W];
    end

    rr_arbiter #(
        .NUM_REQ      (NUM_REQ)
    ) u_arb (
        .req          (req),
        .rr_ptr       (rr_ptr),
        .winner_idx_c (win_idx_c),
        .any_req_c    (any_req_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk_tck) begin
        if (reset) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            tx_data     <= DEFAULT_WORD;
            tx_enable   <= 1'b0;
            tx_reset    <= 1'b1;
            ack         <= '0;
            abort       <= 1'b0;
            busy        <= 1'b0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_ptr_nxt;
            tx_data     <= tx_data_nxt;
            tx_enable   <= tx_enable_nxt;
            tx_reset    <= tx_reset_nxt;
            ack         <= ack_nxt;
            abort       <= abort_nxt;
            busy        <= busy_nxt;
            grant_idx   <= grant_idx_nxt;
            grant_valid <= grant_valid_nxt;
        end
    end

    // Next-state and next-output logic; pulses default low, grant/word hold.
    always_comb begin
        state_nxt       = state;
        rr_ptr_nxt      = rr_ptr;
        tx_data_nxt     = tx_data;
        tx_enable_nxt   = 1'b0;
        tx_reset_nxt    = 1'b0;
        ack_nxt         = '0;
        abort_nxt       = 1'b0;
        grant_idx_nxt   = grant_idx;
        grant_valid_nxt = grant_valid;
        abandon_c       = 1'b0;

        if (capture_dr) begin
            // A capture outside IDLE abandons the scan in flight, then re-arbitrates.
            if (state != ST_IDLE) begin
                abort_nxt    = grant_valid;
                tx_reset_nxt = grant_valid;
            end
            if (any_req_c) begin
                tx_data_nxt     = req_words[win_idx_c];
                grant_idx_nxt   = win_idx_c;
                grant_valid_nxt = 1'b1;
            end else begin
                tx_data_nxt     = DEFAULT_WORD;
                grant_valid_nxt = 1'b0;
            end
            state_nxt = ST_LOADED;
        end else begin
            case (state)
                ST_LOADED: begin
                    if (shift_dr) begin
                        tx_enable_nxt = 1'b1;
                        state_nxt     = ST_SHIFT;
                    end else begin
                        abandon_c = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (tx_done) begin
                        state_nxt = ST_COMPLETE;
                    end else if (shift_dr) begin
                        tx_enable_nxt = 1'b1;
                    end else begin
                        abandon_c = 1'b1;
                    end
                end
                ST_COMPLETE: begin
                    if (update_dr) begin
                        if (grant_valid) begin
                            ack_nxt    = NUM_REQ'(1) << grant_idx;
                            rr_ptr_nxt = IDXW'((32'(grant_idx) + 32'd1) % NUM_REQ);
                        end
                        tx_reset_nxt = 1'b1;
                        state_nxt    = ST_IDLE;
                    end else if (shift_dr) begin
                        abandon_c = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // Abandoned scan: pointer untouched so the same requester wins next time.
        if (abandon_c) begin
            abort_nxt    = grant_valid;
            tx_reset_nxt = grant_valid;
            state_nxt    = ST_IDLE;
        end

        busy_nxt = (state_nxt != ST_IDLE);
    end

endmodule

// File: tb/tb_jtag_dr_tx_scheduler.sv
// Directed plus randomized scans against a scan-level reference model of the scheduler.
module tb_jtag_dr_tx_scheduler;

    localparam int unsigned NR = 4;
    localparam int unsigned WW = 32;
    localparam logic [WW-1:0] DEF = 32'h0000_0000;

    logic               clk_tck = 1'b0;
    logic               reset;
    logic               capture_dr, shift_dr, update_dr, tx_done;
    logic [NR-1:0]      req;
    logic [NR*WW-1:0]   req_data;
    logic [WW-1:0]      tx_data;
    logic               tx_enable, tx_reset, abort, busy, grant_valid;
    logic [NR-1:0]      ack;
    logic [1:0]         grant_idx;

    jtag_dr_tx_scheduler #(
        .NUM_REQ      (NR),
        .WORD_W       (WW),
        .DEFAULT_WORD (DEF)
    ) dut (
        .clk_tck     (clk_tck),
        .reset       (reset),
        .capture_dr  (capture_dr),
        .shift_dr    (shift_dr),
        .update_dr   (update_dr),
        .req         (req),
        .req_data    (req_data),
        .tx_data     (tx_data),
        .tx_enable   (tx_enable),
        .tx_reset    (tx_reset),
        .tx_done     (tx_done),
        .ack         (ack),
        .abort       (abort),
        .busy        (busy),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always #5 clk_tck = ~clk_tck;

    int errors = 0;
    int checks = 0;

    // Reference model: requester words, pointer, and the grant of the current scan.
    logic [WW-1:0] words [NR];
    int            m_ptr;
    int            m_idx;
    logic          m_valid;
    logic [WW-1:0] m_word;

    task automatic tick();
        @(posedge clk_tck);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_data();
        for (int i = 0; i < int'(NR); i++) req_data[i*WW +: WW] = words[i];
    endtask

    // First asserted request at or after ptr, wrapping; -1 when none.
    function automatic int pick(input logic [NR-1:0] r, input int ptr);
        logic [1:0] idx;
        for (int k = 0; k < int'(NR); k++) begin
            idx = 2'((ptr + k) % int'(NR));
            if (r[idx]) return int'(idx);
        end
        return -1;
    endfunction

    task automatic do_reset();
        reset = 1'b1; capture_dr = 0; shift_dr = 0; update_dr = 0; tx_done = 0;
        tick();
        tick();
        check("rst_tx_data", 64'(tx_data), 64'(DEF));
        check("rst_tx_reset", 64'(tx_reset), 64'd1);
        check("rst_tx_enable", 64'(tx_enable), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_abort", 64'(abort), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant_idx", 64'(grant_idx), 64'd0);
        check("rst_grant_valid", 64'(grant_valid), 64'd0);
        reset = 1'b0;
        m_ptr = 0;
        tick();
        check("post_rst_tx_reset", 64'(tx_reset), 64'd0);
    endtask

    task automatic capture_step(input logic exp_abort);
        int p;
        capture_dr = 1'b1; shift_dr = 0; update_dr = 0; tx_done = 0;
        p = pick(req, m_ptr);
        m_valid = (p >= 0);
        if (m_valid) begin
            m_idx  = p;
            m_word = words[p];
        end else begin
            m_word = DEF;
        end
        tick();
        capture_dr = 1'b0;
        check("cap_tx_data", 64'(tx_data), 64'(m_word));
        check("cap_grant_valid", 64'(grant_valid), 64'(m_valid));
        if (m_valid) check("cap_grant_idx", 64'(grant_idx), 64'(m_idx));
        check("cap_busy", 64'(busy), 64'd1);
        check("cap_abort", 64'(abort), 64'(exp_abort));
        check("cap_tx_reset", 64'(tx_reset), 64'(exp_abort));
        check("cap_ack", 64'(ack), 64'd0);
        check("cap_tx_enable", 64'(tx_enable), 64'd0);
    endtask

    // Shift 33 cycles (done on the last) or drop shift_dr at abort_at; scramble alters req_data mid-scan.
    task automatic shift_phase(input int abort_at, input bit scramble);
        bit aborted = 0;
        logic [NR-1:0] exp_ack;
        for (int c = 0; c <= 32; c++) begin
            if (c == abort_at) begin
                aborted = 1;
                break;
            end
            shift_dr = 1'b1;
            tx_done  = (c == 32);
            if (scramble && c == 3) begin
                for (int i = 0; i < int'(NR); i++) words[i] = $urandom;
                set_data();
            end
            tick();
            check("sh_tx_enable", 64'(tx_enable), 64'(c < 32));
        end
        shift_dr = 1'b0;
        tx_done  = 1'b0;
        if (aborted) begin
            tick();
            check("ab_abort", 64'(abort), 64'(m_valid));
            check("ab_tx_reset", 64'(tx_reset), 64'(m_valid));
            check("ab_ack", 64'(ack), 64'd0);
            check("ab_busy", 64'(busy), 64'd0);
            check("ab_tx_enable", 64'(tx_enable), 64'd0);
            tick();
            check("ab_abort_end", 64'(abort), 64'd0);
            return;
        end
        check("sh_tx_data_held", 64'(tx_data), 64'(m_word));
        tick();
        check("cmp_busy", 64'(busy), 64'd1);
        check("cmp_ack", 64'(ack), 64'd0);
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
        exp_ack = m_valid ? (NR'(1) << m_idx) : '0;
        check("upd_ack", 64'(ack), 64'(exp_ack));
        check("upd_tx_reset", 64'(tx_reset), 64'd1);
        check("upd_abort", 64'(abort), 64'd0);
        check("upd_busy", 64'(busy), 64'd0);
        if (m_valid) m_ptr = (m_idx + 1) % int'(NR);
        tick();
        check("upd_ack_end", 64'(ack), 64'd0);
        check("upd_tx_reset_end", 64'(tx_reset), 64'd0);
    endtask

    initial begin
        req = '0;
        for (int i = 0; i < int'(NR); i++) words[i] = 32'h1000_0000 + 32'(i);
        set_data();
        m_ptr = 0; m_idx = 0; m_valid = 0; m_word = DEF;
        do_reset();

        // Normal scan from requester 1; pointer moves to 2, so 1011 picks 3 next.
        words[1] = 32'hDEAD_BEEF;
        set_data();
        req = 4'b0010;
        capture_step(1'b0);
        shift_phase(-1, 1'b0);
        req = 4'b1011;
        capture_step(1'b0);
        check("rr_after_normal", 64'(grant_idx), 64'd3);
        shift_phase(-1, 1'b0);

        // Round robin with all requesting.
        do_reset();
        req = 4'b1111;
        for (int s = 0; s < 4; s++) begin
            capture_step(1'b0);
            check("rr_seq", 64'(grant_idx), 64'(s));
            shift_phase(-1, 1'b0);
        end

        // Empty capture shifts the default word, no ack.
        req = 4'b0000;
        capture_step(1'b0);
        shift_phase(-1, 1'b0);

        // Abort after 10 shift cycles; requester 2 wins again.
        req = 4'b0100;
        capture_step(1'b0);
        shift_phase(10, 1'b0);
        capture_step(1'b0);
        check("regrant_idx", 64'(grant_idx), 64'd2);
        shift_phase(-1, 1'b0);

        // Reset in the middle of a shift clears pointer and outputs.
        capture_step(1'b0);
        for (int c = 0; c < 5; c++) begin
            shift_dr = 1'b1;
            tick();
        end
        reset = 1'b1;
        tick();
        check("mrst_tx_enable", 64'(tx_enable), 64'd0);
        check("mrst_tx_reset", 64'(tx_reset), 64'd1);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_ack", 64'(ack), 64'd0);
        check("mrst_abort", 64'(abort), 64'd0);
        reset = 1'b0; shift_dr = 1'b0;
        m_ptr = 0;
        tick();
        req = 4'b1111;
        capture_step(1'b0);
        check("mrst_rr_zero", 64'(grant_idx), 64'd0);
        shift_phase(-1, 1'b0);

        // Re-capture while LOADED reloads a changed word with an abort pulse.
        do_reset();
        req = 4'b0011;
        words[0] = 32'hA5A5_0001;
        set_data();
        capture_step(1'b0);
        words[0] = 32'h5A5A_0002;
        set_data();
        capture_step(1'b1);
        check("recap_idx", 64'(grant_idx), 64'd0);
        shift_phase(-1, 1'b0);

        // Randomized scans with occasional aborts and mid-scan data changes.
        for (int n = 0; n < 30; n++) begin
            int ab;
            req = 4'($urandom);
            for (int i = 0; i < int'(NR); i++) words[i] = $urandom;
            set_data();
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1;
            capture_step(1'b0);
            shift_phase(ab, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
